// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Valid/ready handshake on operands and on the result.
module seq_divider_16by8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  quot_ovf
);

  localparam int CW = $clog2(DIVIDEND_W);
  localparam int RW = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0]  d;
  logic [RW-1:0]         r;
  logic [CW-1:0]         cnt;

  logic [RW-1:0]         t;
  logic [RW-1:0]         diff;
  logic                  ge;
  logic [RW-1:0]         r_step;
  logic [DIVIDEND_W-1:0] q_step;
  logic                  zero_div;
  logic                  last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero_div  = (divisor == '0);
  assign last      = (cnt == '0);

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // A set top bit of R means the shifted value already exceeds D.
  always_comb begin
    t      = {r[DIVISOR_W-1:0], q[DIVIDEND_W-1]};
    diff   = t - {1'b0, d};
    ge     = r[DIVISOR_W] | (t >= {1'b0, d});
    r_step = t;
    q_step = {q[DIVIDEND_W-2:0], 1'b0};
    if (ge) begin
      r_step = diff;
      q_step = {q[DIVIDEND_W-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic for the handshake and iteration sequence.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = zero_div ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working registers: operand capture and per-cycle iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      d   <= '0;
      r   <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q   <= dividend;
            d   <= divisor;
            r   <= '0;
            cnt <= CW'(DIVIDEND_W - 1);
          end
        end
        CALC: begin
          q   <= q_step;
          r   <= r_step;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: written once per operation, held until next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      quot_ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
            quot_ovf    <= 1'b1;
          end
        end
        CALC: begin
          if (last) begin
            quotient    <= q_step;
            remainder   <= r_step[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            quot_ovf    <= |q_step[DIVIDEND_W-1:DIVISOR_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider_16by8.md
Name: seq_divider_16by8

Overview:
Sequential unsigned restoring divider. It is the inverse datapath of the 8x8 Wallace-tree multiplier: it divides a 16-bit product-width dividend by an 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder. It computes one quotient bit per clock and uses a valid/ready handshake on both input and output. The approximate-multiplier flow uses it to recover operands and measure multiplier error.

Parameters:
DIVIDEND_W, 16, dividend and quotient width
DIVISOR_W, 8, divisor and remainder width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block idle, can accept operands
dividend  input  DIVIDEND_W  unsigned dividend
divisor  input  DIVISOR_W  unsigned divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  DIVIDEND_W  unsigned quotient
remainder  output  DIVISOR_W  unsigned remainder
div_by_zero  output  1  divisor was 0
quot_ovf  output  1  quotient exceeds DIVISOR_W bits (quotient[15:8] != 0)

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state goes to IDLE. in_ready=1 after reset release. out_valid=0. quotient, remainder, div_by_zero, quot_ovf, the internal partial remainder, the shift register and the counter are all 0.
- FSM states are IDLE, CALC and DONE.
- IDLE: in_ready=1. On in_valid=1 at a clock edge (the accept edge):
  - Latch dividend into the quotient/dividend shift register Q.
  - Latch divisor into D.
  - Clear the partial remainder R (DIVISOR_W+1 bits).
  - Set the counter to DIVIDEND_W-1.
  - If divisor==0: go directly to DONE with quotient=16'hFFFF, remainder=dividend[7:0], div_by_zero=1, quot_ovf=1.
  - Otherwise: go to CALC.
- CALC: in_ready=0. Each edge performs:
  - T = {R[DIVISOR_W-1:0], Q[MSB]}.
  - If T >= {1'b0,D}: R = T-D and Q = {Q[MSB-1:0],1}. Otherwise: R = T and Q = {Q[MSB-1:0],0}.
  - Compare on DIVISOR_W+1 bits; no truncation.
  - Counter decrements. On the edge where the counter is 0, the result is written to the outputs and the state goes to DONE.
- Latency: out_valid rises exactly 16 edges after the accept edge for a nonzero divisor, and 1 edge after it for divisor==0.
- DONE: out_valid=1. quotient, remainder and the flags stay stable until the edge where out_ready=1; that edge goes to IDLE with out_valid=0.
- Outputs keep their last values in IDLE. Only out_valid qualifies them.
- in_ready=1 only in IDLE. There is no accept in the same cycle as result handoff, so there is a minimum 1-cycle bubble between operations.
- in_valid while busy is ignored and not queued. Operands need not be held after the accept edge.
- Result invariant for divisor!=0: dividend == quotient*divisor + remainder, with remainder < divisor.
- Asynchronous reset mid-CALC or mid-DONE aborts immediately: all state returns to reset values and no partial result is presented.

Test Plan:
1. Exact division: dividend=65025, divisor=255 -> after 16 edges out_valid=1, quotient=255, remainder=0, quot_ovf=0, div_by_zero=0.
2. Remainder case: 1000/7 -> quotient=142, remainder=6. Then 65535/1 -> quotient=65535, remainder=0, quot_ovf=1.
3. Divide by zero: dividend=16'h04D2, divisor=0 -> out_valid 1 edge after accept, quotient=16'hFFFF, remainder=8'hD2, div_by_zero=1.
4. Backpressure: 1000/7 with out_ready=0 for 5 cycles after out_valid -> outputs stay 142/6 and in_ready=0 throughout. in_valid pulses during CALC/DONE with other operands do not change the result. Set out_ready=1 -> IDLE next edge, in_ready=1.
5. Reset mid-operation: assert rst 8 edges into CALC -> out_valid=0, in_ready=1 and all outputs 0 immediately, without waiting for a clock edge. A following 100/9 gives quotient=11, remainder=1.
6. Round trip with the multiplier: for 2000 random a and nonzero b (8-bit), divide the multiplier result by b -> quotient==a, remainder==0, quot_ovf=0.
